// File: rtl/unidad_pc_pkg.sv
// Shared types and defaults for the program-counter unit and its target adder.
package pkg_unidad_pc;

    typedef enum logic {
        LIBRE   = 1'b0,
        CALCULO = 1'b1
    } estado_t;

    localparam int ANCHO_DEF      = 64;
    localparam int INCREMENTO_DEF = 4;
    localparam int DESPL_DEF      = 2;

    // Reset address trimmed to the datapath width so a wide default never leaks into high bits.
    function automatic logic [ANCHO_DEF-1:0] dir_reset_ajustada(
        input logic [ANCHO_DEF-1:0] dir,
        input int                   ancho
    );
        logic [ANCHO_DEF-1:0] mascara;
        mascara = '0;
        for (int i = 0; i < ANCHO_DEF; i++) begin
            if (i < ancho) mascara[i] = 1'b1;
        end
        return dir & mascara;
    endfunction

    localparam logic [ANCHO_DEF-1:0] DIR_RESET_DEF = dir_reset_ajustada('0, ANCHO_DEF);

endpackage

// File: rtl/unidad_pc_sumador_objetivo.sv
// Registered shift-and-add stage: suma = base + (offset << DESPL), with the unsigned carry-out.
module sumador_objetivo #(
    parameter int ANCHO = 64,
    parameter int DESPL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cargar,
    input  logic [ANCHO-1:0] base,
    input  logic [ANCHO-1:0] offset,
    output logic [ANCHO-1:0] suma,
    output logic             acarreo
);

    logic [ANCHO-1:0] desplazado;
    logic [ANCHO:0]   total;

    // Shifted-out offset bits are dropped; the extra sum bit carries the unsigned overflow.
    always_comb begin
        desplazado = offset << DESPL;
        total      = {1'b0, base} + {1'b0, desplazado};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            suma    <= '0;
            acarreo <= 1'b0;
        end else if (cargar) begin
            suma    <= total[ANCHO-1:0];
            acarreo <= total[ANCHO];
        end
    end

endmodule

// File: rtl/unidad_pc.sv
// Registered next-PC unit: sequential increment with stall, plus handshaked branch redirects.
module unidad_pc
    import pkg_unidad_pc::*;
#(
    parameter int               ANCHO      = ANCHO_DEF,
    parameter int               INCREMENTO = INCREMENTO_DEF,
    parameter int               DESPL      = DESPL_DEF,
    parameter logic [ANCHO-1:0] DIR_RESET  = ANCHO'(DIR_RESET_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [ANCHO-1:0] br_base,
    input  logic [ANCHO-1:0] br_offset,
    output logic [ANCHO-1:0] pc,
    output logic             redireccion,
    output logic             desborde
);

    localparam logic [ANCHO-1:0] PASO = ANCHO'(INCREMENTO);

    estado_t          estado;
    estado_t          estado_sig;
    logic             aceptar;
    logic [ANCHO-1:0] objetivo;
    logic             acarreo;

    sumador_objetivo #(
        .ANCHO (ANCHO),
        .DESPL (DESPL)
    ) u_sumador (
        .clk     (clk),
        .rst     (rst),
        .cargar  (aceptar),
        .base    (br_base),
        .offset  (br_offset),
        .suma    (objetivo),
        .acarreo (acarreo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= LIBRE;
        else     estado <= estado_sig;
    end

    // br_ready depends only on the state, so there is no path from br_valid back to br_ready.
    always_comb begin
        estado_sig = estado;
        br_ready   = 1'b0;
        aceptar    = 1'b0;
        case (estado)
            LIBRE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    aceptar    = 1'b1;
                    estado_sig = CALCULO;
                end
            end
            CALCULO: estado_sig = LIBRE;
            default: estado_sig = LIBRE;
        endcase
    end

    // A pending target load wins over both stall and the sequential increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= DIR_RESET;
            redireccion <= 1'b0;
            desborde    <= 1'b0;
        end else if (estado == CALCULO) begin
            pc          <= objetivo;
            desborde    <= acarreo;
            redireccion <= 1'b1;
        end else begin
            redireccion <= 1'b0;
            if (!stall) pc <= pc + PASO;
        end
    end

endmodule
